// File: rtl/hex_display_scheduler_pkg.sv
// Shared types and defaults for the hex display scheduler.
package hex_display_scheduler_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } state_e;

  // One-second slice at the 50 MHz DE1-SoC board clock.
  localparam int unsigned DwellCyclesDefault = 50_000_000;

endpackage

// File: rtl/hex_display_scheduler_rr_pick.sv
// Combinational round-robin pick: the first set request scanning upward from start, wrapping.
module hex_display_scheduler_rr_pick #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned ID_W       = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req,
  input  logic [ID_W-1:0]       start,
  output logic                  valid,
  output logic [REQUESTERS-1:0] pick_onehot,
  output logic [ID_W-1:0]       pick_idx
);

  always_comb begin
    int unsigned j;
    valid       = 1'b0;
    pick_onehot = '0;
    pick_idx    = '0;
    j           = 0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      j = 32'(start) + i;
      if (j >= REQUESTERS) j = j - REQUESTERS;
      if (!valid && req[ID_W'(j)]) begin
        valid                    = 1'b1;
        pick_onehot[ID_W'(j)]    = 1'b1;
        pick_idx                 = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Round-robin time-sharing of one seven-segment bank with a dwell timer.
// Define HEX_SCHED_ZERO_BLANK_EN to darken leading zero digits while a client owns the bank.
module hex_display_scheduler
  import hex_display_scheduler_pkg::*;
#(
  parameter int unsigned DISPLAYS     = 6,
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned DWELL_CYCLES = DwellCyclesDefault,
  parameter int unsigned ID_W         = $clog2(REQUESTERS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [REQUESTERS-1:0]          req,
  input  logic [REQUESTERS*4*DISPLAYS-1:0] req_hex,
  output logic [REQUESTERS-1:0]          grant,
  output logic [ID_W-1:0]                owner_id,
  output logic [4*DISPLAYS-1:0]          hex,
  output logic [DISPLAYS-1:0]            blank
);

  localparam int unsigned HW = 4 * DISPLAYS;
  localparam int unsigned TW = $clog2(DWELL_CYCLES);
  localparam logic [TW-1:0]   Reload   = TW'(DWELL_CYCLES - 1);
  localparam logic [ID_W-1:0] LastInit = ID_W'(REQUESTERS - 1);

  state_e                state_q, state_d;
  logic [REQUESTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [HW-1:0]         hex_q, hex_d;
  logic [DISPLAYS-1:0]   blank_q, blank_d;

  logic                  pick_valid;
  logic [REQUESTERS-1:0] pick_onehot;
  logic [ID_W-1:0]       pick_idx;
  logic [ID_W-1:0]       pick_start;
  logic [REQUESTERS-1:0] pick_req;

  // last_q equals the owner while OWNED, so one picker serves both states; the owner's own bit
  // is masked so a rotation only ever lands on another client.
  assign pick_start = (last_q == LastInit) ? '0 : last_q + 1'b1;
  assign pick_req   = req & ~grant_q;

  hex_display_scheduler_rr_pick #(
    .REQUESTERS (REQUESTERS),
    .ID_W       (ID_W)
  ) u_rr_pick (
    .req         (pick_req),
    .start       (pick_start),
    .valid       (pick_valid),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StOwned;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          last_d  = pick_idx;
          timer_d = Reload;
        end
      end
      StOwned: begin
        if (!req[owner_q] || timer_q == '0) begin
          if (pick_valid) begin
            grant_d = pick_onehot;
            owner_d = pick_idx;
            last_d  = pick_idx;
            timer_d = Reload;
          end else if (!req[owner_q]) begin
            state_d = StIdle;
            grant_d = '0;
            owner_d = '0;
            timer_d = '0;
          end else begin
            timer_d = Reload;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        owner_d = '0;
      end
    endcase
  end

  // Display registers follow the next owner so they switch on the same edge as grant.
  always_comb begin
    hex_d = '0;
    if (state_d == StOwned) begin
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
        if (owner_d == ID_W'(i)) hex_d = req_hex[i*HW +: HW];
      end
    end
  end

  always_comb begin
    blank_d = '1;
    if (state_d == StOwned) begin
      blank_d = '0;
`ifdef HEX_SCHED_ZERO_BLANK_EN
      begin
        logic lead;
        lead = 1'b1;
        for (int d = DISPLAYS - 1; d >= 1; d--) begin
          if (lead && hex_d[d*4 +: 4] == 4'h0) blank_d[d] = 1'b1;
          else lead = 1'b0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LastInit;
      timer_q <= '0;
      hex_q   <= '0;
      blank_q <= '1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
    end
  end

  assign grant    = grant_q;
  assign owner_id = owner_q;
  assign hex      = hex_q;
  assign blank    = blank_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench: ownership model plus directed literal checks.
module tb_hex_display_scheduler;

  localparam int R = 4;
  localparam int D = 6;
  localparam int DW = 8;
`ifdef HEX_SCHED_ZERO_BLANK_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [R-1:0]  req = '0;
  logic [R*4*D-1:0] req_hex = '0;
  logic [R-1:0]  grant;
  logic [1:0]    owner_id;
  logic [4*D-1:0] hex;
  logic [D-1:0]  blank;

  int tests = 0;
  int fails = 0;

  hex_display_scheduler #(
    .DISPLAYS     (D),
    .REQUESTERS   (R),
    .DWELL_CYCLES (DW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_hex  (req_hex),
    .grant    (grant),
    .owner_id (owner_id),
    .hex      (hex),
    .blank    (blank)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // First requester after 'after', wrapping; -1 when none.
  function automatic int rr(input logic [R-1:0] r, input int after);
    for (int k = 1; k <= R; k++) begin
      if (r[(after + k) % R]) return (after + k) % R;
    end
    return -1;
  endfunction

  function automatic logic [D-1:0] blank_of(input logic [4*D-1:0] v);
    int nd;
    int m;
    nd = 1;
    for (int d = 0; d < D; d++) if (v[d*4 +: 4] != 4'h0) nd = d + 1;
    m = (1 << nd) - 1;
    return ZB ? D'(63 & ~m) : '0;
  endfunction

  // Model: who owns the bank and how many cycles of the slice have elapsed.
  int m_owner = -1;
  int m_age = 0;
  int m_last = R - 1;
  logic [4*D-1:0] m_hex = '0;
  logic [D-1:0] m_blank = '1;

  always @(posedge clock or negedge reset) begin
    int nxt;
    int o;
    if (!reset) begin
      m_owner = -1; m_age = 0; m_last = R - 1; m_hex = '0; m_blank = '1;
    end else begin
      nxt = m_owner;
      if (m_owner < 0) begin
        nxt = rr(req, m_last);
        m_age = 0;
      end else if (!req[m_owner]) begin
        nxt = rr(req, m_owner);
        m_age = 0;
      end else if (m_age == DW - 1) begin
        o = rr(req & ~(R'(1) << m_owner), m_owner);
        if (o >= 0) nxt = o;
        m_age = 0;
      end else begin
        m_age++;
      end
      m_owner = nxt;
      if (nxt >= 0) m_last = nxt;
      m_hex = (nxt >= 0) ? req_hex[nxt*4*D +: 4*D] : '0;
      m_blank = (nxt >= 0) ? blank_of(m_hex) : '1;
    end
  end

  always @(negedge clock) begin
    logic [R-1:0] eg;
    eg = (m_owner < 0) ? '0 : R'(1) << m_owner;
    chk("model_grant", 32'(grant), 32'(eg));
    chk("model_owner_id", 32'(owner_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("model_hex", 32'(hex), 32'(m_hex));
    chk("model_blank", 32'(blank), 32'(m_blank));
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Counts cycles until grant changes, bounded.
  task automatic slice_len(output int cnt);
    logic [R-1:0] g0;
    g0 = grant;
    cnt = 0;
    while (grant == g0 && cnt < 20) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    logic [R-1:0] seq [4];
    int cnt;
    seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0001; seq[3] = 4'b0010;
    req_hex[0*24 +: 24] = 24'h0012AB;
    req_hex[1*24 +: 24] = 24'h000305;
    req_hex[2*24 +: 24] = 24'h000000;
    req_hex[3*24 +: 24] = 24'hFEDCBA;

    // Reset state
    step(); step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_hex", 32'(hex), 32'h0);
    chk("rst_blank", 32'(blank), 32'h3F);
    chk("rst_owner", 32'(owner_id), 32'h0);
    reset = 1'b1;
    step();

    // Single requester, held indefinitely with live value updates
    req = 4'b0001;
    step();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_hex", 32'(hex), 32'h0012AB);
    chk("single_blank", 32'(blank), ZB ? 32'h30 : 32'h0);
    repeat (20) step();
    chk("single_hold", 32'(grant), 32'h1);
    req_hex[0*24 +: 24] = 24'h00ABCD;
    step();
    chk("live_hex", 32'(hex), 32'h00ABCD);
    req_hex[0*24 +: 24] = 24'h0012AB;
    step();

    // Drop to idle, then all request: rotation from last_owner+1, 8-cycle slices
    req = 4'b0000;
    step();
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_blank", 32'(blank), 32'h3F);
    req = 4'b1111;
    step();
    chk("rr_first", 32'(grant), 32'h2);
    for (int s = 0; s < 4; s++) begin
      slice_len(cnt);
      chk("rr_slice_len", 32'(cnt), 32'd8);
      chk("rr_next", 32'(grant), 32'(seq[s]));
    end

    // Owner 1 drops mid-slice while client 3 requests
    step(); step();
    req = 4'b1001;
    step();
    chk("drop_handover", 32'(grant), 32'h8);
    chk("drop_owner_id", 32'(owner_id), 32'd3);
    slice_len(cnt);
    chk("drop_fresh_slice", 32'(cnt), 32'd8);
    chk("drop_rotate", 32'(grant), 32'h1);

    // Sole owner drops -> idle; re-request picked from last_owner+1
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    chk("sole_idle_grant", 32'(grant), 32'h0);
    chk("sole_idle_blank", 32'(blank), 32'h3F);
    chk("sole_idle_hex", 32'(hex), 32'h0);
    req = 4'b0100;
    step();
    chk("rereq_grant", 32'(grant), 32'h4);
    chk("zero_hex", 32'(hex), 32'h0);
    chk("zero_blank", 32'(blank), ZB ? 32'h3E : 32'h0);
    req = 4'b0010;
    step();
    chk("b305_grant", 32'(grant), 32'h2);
    chk("b305_hex", 32'(hex), 32'h000305);
    chk("b305_blank", 32'(blank), ZB ? 32'h38 : 32'h0);

    // Asynchronous reset mid-slice; RR order restarts at client 0
    step(); step(); step();
    #1 reset = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_hex", 32'(hex), 32'h0);
    chk("async_blank", 32'(blank), 32'h3F);
    chk("async_owner", 32'(owner_id), 32'h0);
    step(); step();
    reset = 1'b1;
    req = 4'b1111;
    step();
    chk("restart_grant", 32'(grant), 32'h1);
    chk("restart_hex", 32'(hex), 32'h0012AB);
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
